// File: rtl/alu_scoreboard.sv
// In-order scoreboard comparing ALU responses against expected packets, with timeout,
// orphan detection and a fail log. Optional per-bit compare mask when ALU_SCB_MASK_EN is defined.
module alu_scoreboard #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned FID_W     = 8,
  parameter int unsigned EXP_DEPTH = 4,
  parameter int unsigned LOG_DEPTH = 16,
  parameter int unsigned TIMEOUT   = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 exp_valid,
  output logic                 exp_ready,
  input  logic [FID_W-1:0]     exp_fid,
  input  logic [2*WIDTH-1:0]   exp_res,
  input  logic [7:0]           exp_flags,
`ifdef ALU_SCB_MASK_EN
  input  logic [2*WIDTH+7:0]   exp_mask,
`endif
  input  logic                 rsp_valid,
  input  logic [2*WIDTH-1:0]   rsp_res,
  input  logic [7:0]           rsp_flags,
  output logic                 fail_valid,
  input  logic                 fail_rd,
  output logic [FID_W-1:0]     fail_fid,
  output logic [1:0]           fail_cause,
  output logic [CNT_W-1:0]     pass_cnt,
  output logic [CNT_W-1:0]     fail_cnt,
  output logic                 fail_ovf,
  output logic                 idle
);

  localparam int unsigned RES_W = 2 * WIDTH;
  localparam int unsigned CMP_W = RES_W + 8;
  localparam int unsigned EA_W  = $clog2(EXP_DEPTH);
  localparam int unsigned EP_W  = EA_W + 1;
  localparam int unsigned LA_W  = $clog2(LOG_DEPTH);
  localparam int unsigned LP_W  = LA_W + 1;
  localparam int unsigned TO_W  = 8;

  localparam logic [1:0] CAUSE_MISMATCH = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
  localparam logic [1:0] CAUSE_ORPHAN   = 2'b11;

  typedef enum logic {S_EMPTY, S_WAIT} head_state_t;

  // Expected queue storage and pointers (extra MSB distinguishes full from empty)
  logic [FID_W-1:0] eq_fid  [EXP_DEPTH];
  logic [CMP_W-1:0] eq_data [EXP_DEPTH];
  logic [EP_W-1:0]  eq_wr_ptr, eq_rd_ptr;
  logic [EA_W-1:0]  eq_head;
  logic             eq_full, eq_empty, eq_last;
  logic [CMP_W-1:0] head_mask;
  logic             head_match;

  // Fail log storage and pointers
  logic [FID_W-1:0] lg_fid   [LOG_DEPTH];
  logic [1:0]       lg_cause [LOG_DEPTH];
  logic [LP_W-1:0]  lg_wr_ptr, lg_rd_ptr;
  logic             lg_full, lg_empty, lg_pop, lg_accept;

  head_state_t      state, state_nxt;
  logic [TO_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic             push, pop, log_wr, pass_inc, fail_inc;
  logic [FID_W-1:0] log_fid;
  logic [1:0]       log_cause;

  assign eq_head  = eq_rd_ptr[EA_W-1:0];
  assign eq_empty = (eq_wr_ptr == eq_rd_ptr);
  assign eq_full  = (eq_wr_ptr[EA_W] != eq_rd_ptr[EA_W]) &&
                    (eq_wr_ptr[EA_W-1:0] == eq_rd_ptr[EA_W-1:0]);
  assign eq_last  = ((eq_wr_ptr - eq_rd_ptr) == EP_W'(1));
  assign push     = exp_valid && !eq_full;

`ifdef ALU_SCB_MASK_EN
  logic [CMP_W-1:0] eq_mask [EXP_DEPTH];
  assign head_mask = eq_mask[eq_head];
`else
  assign head_mask = {CMP_W{1'b1}};
`endif

  assign head_match = ((({rsp_res, rsp_flags} ^ eq_data[eq_head]) & head_mask) == '0);

  assign lg_empty  = (lg_wr_ptr == lg_rd_ptr);
  assign lg_full   = (lg_wr_ptr[LA_W] != lg_rd_ptr[LA_W]) &&
                     (lg_wr_ptr[LA_W-1:0] == lg_rd_ptr[LA_W-1:0]);
  assign lg_pop    = fail_rd && !lg_empty;
  assign lg_accept = log_wr && (!lg_full || lg_pop);

  assign exp_ready  = !eq_full;
  assign idle       = eq_empty;
  assign fail_valid = !lg_empty;
  assign fail_fid   = lg_empty ? '0 : lg_fid[lg_rd_ptr[LA_W-1:0]];
  assign fail_cause = lg_empty ? '0 : lg_cause[lg_rd_ptr[LA_W-1:0]];

  // Head FSM: compare, timeout and orphan decisions for the current cycle
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    pop          = 1'b0;
    log_wr       = 1'b0;
    log_fid      = '0;
    log_cause    = '0;
    pass_inc     = 1'b0;
    fail_inc     = 1'b0;
    case (state)
      S_EMPTY: begin
        if (rsp_valid) begin
          fail_inc  = 1'b1;
          log_wr    = 1'b1;
          log_fid   = '1;
          log_cause = CAUSE_ORPHAN;
        end
        if (push) begin
          state_nxt    = S_WAIT;
          wait_cnt_nxt = '0;
        end
      end
      S_WAIT: begin
        if (rsp_valid) begin
          pop = 1'b1;
          if (head_match) begin
            pass_inc = 1'b1;
          end else begin
            fail_inc  = 1'b1;
            log_wr    = 1'b1;
            log_fid   = eq_fid[eq_head];
            log_cause = CAUSE_MISMATCH;
          end
        end else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
          pop       = 1'b1;
          fail_inc  = 1'b1;
          log_wr    = 1'b1;
          log_fid   = eq_fid[eq_head];
          log_cause = CAUSE_TIMEOUT;
        end else begin
          wait_cnt_nxt = wait_cnt + TO_W'(1);
        end
        if (pop) begin
          wait_cnt_nxt = '0;
          if (eq_last && !push) state_nxt = S_EMPTY;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_EMPTY;
      wait_cnt  <= '0;
      eq_wr_ptr <= '0;
      eq_rd_ptr <= '0;
      lg_wr_ptr <= '0;
      lg_rd_ptr <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
      fail_ovf  <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (push)      eq_wr_ptr <= eq_wr_ptr + EP_W'(1);
      if (pop)       eq_rd_ptr <= eq_rd_ptr + EP_W'(1);
      if (lg_accept) lg_wr_ptr <= lg_wr_ptr + LP_W'(1);
      if (lg_pop)    lg_rd_ptr <= lg_rd_ptr + LP_W'(1);
      if (pass_inc && (pass_cnt != '1)) pass_cnt <= pass_cnt + CNT_W'(1);
      if (fail_inc && (fail_cnt != '1)) fail_cnt <= fail_cnt + CNT_W'(1);
      if (log_wr && lg_full && !lg_pop) fail_ovf <= 1'b1;
    end
  end

  // Storage writes; when the log is full a write lands in the slot being popped
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      eq_fid[eq_wr_ptr[EA_W-1:0]]  <= exp_fid;
      eq_data[eq_wr_ptr[EA_W-1:0]] <= {exp_res, exp_flags};
`ifdef ALU_SCB_MASK_EN
      eq_mask[eq_wr_ptr[EA_W-1:0]] <= exp_mask;
`endif
    end
    if (!rst && lg_accept) begin
      lg_fid[lg_wr_ptr[LA_W-1:0]]   <= log_fid;
      lg_cause[lg_wr_ptr[LA_W-1:0]] <= log_cause;
    end
  end

endmodule
